// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ADD/SUB/logic ops, WIDTH-iteration shift-add MUL
// and restoring DIV, with a one-cycle DONE/FLAGS_EN strobe per operation.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] REMAINDER,
  output logic [3:0]       FLAGS,
  output logic             FLAGS_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIV_ERR
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_DIV = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIN} state_t;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_w, r_q, r_d;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_sum, w_shl;
  logic [WIDTH-1:0] w_trial, w_w_nxt, w_q_nxt;
  logic             w_ge, w_iter_op, w_load;
  logic [WIDTH-1:0] w_res, w_rem;
  logic             w_c, w_v, w_err;

  // r_w is the product high half (MUL) or partial remainder (DIV); r_q holds
  // the multiplier / dividend bits shifting out and the result bits shifting in.
  always_comb begin
    w_sum   = {1'b0, r_w} + (r_q[0] ? {1'b0, r_d} : '0);
    w_shl   = {r_w, r_q[WIDTH-1]};
    w_ge    = (w_shl >= {1'b0, r_d});
    w_trial = w_shl[WIDTH-1:0] - r_d;
    if (r_op == OP_MUL) begin
      w_w_nxt = w_sum[WIDTH:1];
      w_q_nxt = {w_sum[0], r_q[WIDTH-1:1]};
    end else begin
      w_w_nxt = w_ge ? w_trial : w_shl[WIDTH-1:0];
      w_q_nxt = {r_q[WIDTH-2:0], w_ge};
    end
  end

  assign w_iter_op = (OP == OP_MUL) || (OP == OP_DIV);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (START) w_state_nxt = w_iter_op ? S_ITER : S_FIN;
      S_ITER:  if (r_cnt == CW'(1)) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_load = (w_state_nxt == S_FIN) && (r_state != S_FIN);

  // Result for the edge entering FIN: either from the live operands (direct
  // ops) or from the final iteration of the working registers.
  always_comb begin
    w_res = '0;
    w_rem = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    if (r_state == S_ITER) begin
      w_res = w_q_nxt;
      if (r_op == OP_MUL) begin
        w_c = |w_w_nxt;
        w_v = w_c;
      end else begin
        w_rem = w_w_nxt;
        if (r_d == '0) begin
          w_v   = 1'b1;
          w_err = 1'b1;
        end
      end
    end else begin
      case (OP)
        OP_ADD: begin
          {w_c, w_res} = {1'b0, A} + {1'b0, B};
          w_v = (A[WIDTH-1] == B[WIDTH-1]) && (w_res[WIDTH-1] != A[WIDTH-1]);
        end
        OP_SUB: begin
          w_res = A - B;
          w_c   = (A < B);
          w_v   = (A[WIDTH-1] != B[WIDTH-1]) && (w_res[WIDTH-1] != A[WIDTH-1]);
        end
        OP_AND:  w_res = A & B;
        OP_OR:   w_res = A | B;
        OP_XOR:  w_res = A ^ B;
        default: w_res = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_w       <= '0;
      r_q       <= '0;
      r_d       <= '0;
      r_cnt     <= '0;
      RESULT    <= '0;
      REMAINDER <= '0;
      FLAGS     <= '0;
      DIV_ERR   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && START) begin
        r_op  <= OP;
        r_w   <= '0;
        r_q   <= (OP == OP_MUL) ? B : A;
        r_d   <= (OP == OP_MUL) ? A : B;
        r_cnt <= CW'(WIDTH);
      end else if (r_state == S_ITER) begin
        r_w   <= w_w_nxt;
        r_q   <= w_q_nxt;
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_load) begin
        RESULT    <= w_res;
        REMAINDER <= w_rem;
        FLAGS     <= {(w_res == '0), w_res[WIDTH-1], w_c, w_v};
        DIV_ERR   <= w_err;
      end
    end
  end

  assign BUSY     = (r_state != S_IDLE);
  assign DONE     = (r_state == S_FIN);
  assign FLAGS_EN = (r_state == S_FIN);

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed and random operations checked against an
// arithmetic reference model, plus START-ignore and mid-operation reset cases.
module tb_alu_seq;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         START = 1'b0;
  logic [2:0]   OP = '0;
  logic [W-1:0] A = '0, B = '0;
  logic [W-1:0] RESULT, REMAINDER;
  logic [3:0]   FLAGS;
  logic         FLAGS_EN, BUSY, DONE, DIV_ERR;

  int n_pass = 0;
  int n_total = 0;

  alu_seq #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OP(OP), .A(A), .B(B),
    .RESULT(RESULT), .REMAINDER(REMAINDER), .FLAGS(FLAGS),
    .FLAGS_EN(FLAGS_EN), .BUSY(BUSY), .DONE(DONE), .DIV_ERR(DIV_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] res, output logic [7:0] rem,
                                output logic [3:0] fl, output logic err);
    int ua, ub, sa, sb, r;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    c = 1'b0; v = 1'b0; err = 1'b0; rem = '0; r = 0;
    case (op)
      3'd0: begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      3'd1: begin r = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: begin r = ua * ub; c = (r > 255); v = c; end
      3'd6: begin
        if (ub == 0) begin r = 255; rem = a; v = 1'b1; err = 1'b1; end
        else begin r = ua / ub; rem = 8'(ua % ub); end
      end
      default: r = 0;
    endcase
    res = 8'(r);
    fl  = {(res == 8'h00), res[7], c, v};
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input bit toggle);
    logic [7:0] er, erm;
    logic [3:0] ef;
    logic       ee;
    int lat, nd, nf, nb, exp_lat;
    bit seen;
    model(op, a, b, er, erm, ef, ee);
    exp_lat = (op == 3'd5 || op == 3'd6) ? W + 1 : 1;
    @(negedge CLK);
    START = 1'b1; OP = op; A = a; B = b;
    @(posedge CLK); #1;
    lat = 0; nd = 0; nf = 0; nb = 0; seen = 1'b0;
    for (int cyc = 1; cyc <= W + 6; cyc++) begin
      if (BUSY) nb++;
      if (DONE) nd++;
      if (FLAGS_EN) nf++;
      if (DONE && !seen) begin
        seen = 1'b1;
        lat  = cyc;
        chk($sformatf("result op%0d %h,%h", op, a, b), 32'(RESULT), 32'(er));
        chk($sformatf("remainder op%0d %h,%h", op, a, b), 32'(REMAINDER), 32'(erm));
        chk($sformatf("flags op%0d %h,%h", op, a, b), 32'(FLAGS), 32'(ef));
        chk($sformatf("div_err op%0d %h,%h", op, a, b), 32'(DIV_ERR), 32'(ee));
      end
      if (seen && cyc > lat) break;
      if (seen) START = 1'b0;
      else START = toggle ? ~START : 1'b0;
      OP = 3'($urandom_range(0, 7));
      A  = 8'($urandom);
      B  = 8'($urandom);
      @(posedge CLK); #1;
    end
    START = 1'b0;
    chk($sformatf("latency op%0d", op), 32'(lat), 32'(exp_lat));
    chk($sformatf("done pulses op%0d", op), 32'(nd), 32'd1);
    chk($sformatf("flags_en pulses op%0d", op), 32'(nf), 32'd1);
    chk($sformatf("busy cycles op%0d", op), 32'(nb), 32'(exp_lat));
    chk($sformatf("result held op%0d", op), 32'(RESULT), 32'(er));
  endtask

  initial begin
    int nd;
    // Reset state
    #12;
    chk("reset result", 32'(RESULT), 32'd0);
    chk("reset remainder", 32'(REMAINDER), 32'd0);
    chk("reset flags", 32'(FLAGS), 32'd0);
    chk("reset ctrl", 32'({FLAGS_EN, BUSY, DONE, DIV_ERR}), 32'd0);
    @(negedge CLK); RESET = 1'b1;

    // Directed cases
    run_op(3'd0, 8'h7F, 8'h01, 1'b0);
    run_op(3'd1, 8'h05, 8'h05, 1'b0);
    run_op(3'd1, 8'h03, 8'h05, 1'b0);
    run_op(3'd5, 8'h10, 8'h10, 1'b0);
    run_op(3'd5, 8'h0C, 8'h0B, 1'b0);
    run_op(3'd6, 8'd200, 8'd7, 1'b0);
    run_op(3'd6, 8'h2A, 8'h00, 1'b0);
    run_op(3'd6, 8'd10, 8'd3, 1'b0);
    run_op(3'd2, 8'hF0, 8'h3C, 1'b0);
    run_op(3'd3, 8'h00, 8'h00, 1'b0);
    run_op(3'd4, 8'hA5, 8'h5A, 1'b0);
    run_op(3'd7, 8'h12, 8'h34, 1'b0);
    run_op(3'd5, 8'hFF, 8'hFF, 1'b0);
    run_op(3'd0, 8'h80, 8'h80, 1'b0);
    run_op(3'd1, 8'h80, 8'h01, 1'b0);

    // START toggling during MUL must not queue or restart
    run_op(3'd5, 8'h23, 8'h45, 1'b1);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      logic [2:0] rop;
      logic [7:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)));
    end

    // Reset mid-DIV, with non-zero outputs left by a divide-by-zero
    run_op(3'd6, 8'h2A, 8'h00, 1'b0);
    @(negedge CLK);
    START = 1'b1; OP = 3'd6; A = 8'd200; B = 8'd7;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("busy before abort", 32'(BUSY), 32'd1);
    RESET = 1'b0;
    #1;
    chk("abort result", 32'(RESULT), 32'd0);
    chk("abort remainder", 32'(REMAINDER), 32'd0);
    chk("abort flags", 32'(FLAGS), 32'd0);
    chk("abort ctrl", 32'({FLAGS_EN, BUSY, DONE, DIV_ERR}), 32'd0);
    @(negedge CLK); RESET = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      if (DONE || BUSY) nd++;
    end
    chk("no stale done", 32'(nd), 32'd0);
    run_op(3'd0, 8'h01, 8'h01, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Sequential arithmetic/logic unit for the pocket calculator datapath, directly upstream of the flags register. Accepts one operation per START handshake and executes ADD/SUB/logic ops in one cycle and MUL/DIV as WIDTH-iteration shift-add / restoring-divide loops. On completion it presents RESULT and a 4-bit flag vector. It pulses FLAGS_EN so the flags register captures the flags exactly once per operation.

Parameters:
WIDTH, 8, operand/result width in bits (>=4)

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-low reset
START  input  1  request; sampled only in IDLE
OP  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 DIV, 111 reserved
A  input  WIDTH  operand A (dividend / multiplicand)
B  input  WIDTH  operand B (divisor / multiplier)
RESULT  output  WIDTH  registered result
REMAINDER  output  WIDTH  DIV remainder; 0 for all other ops
FLAGS  output  4  bit0 overflow V, bit1 carry C, bit2 negative N, bit3 zero Z
FLAGS_EN  output  1  one-cycle strobe, FLAGS valid; drives the flags register EN
BUSY  output  1  high from accept until DONE cycle inclusive
DONE  output  1  one-cycle completion pulse (identical timing to FLAGS_EN)
DIV_ERR  output  1  set with DONE when DIV has B==0; held until next completion

Behaviour:
- Reset (RESET low, asynchronous): state IDLE; RESULT, REMAINDER, FLAGS, FLAGS_EN, BUSY, DONE, DIV_ERR all 0; iteration counter and shift registers cleared. Reset mid-operation aborts it; no DONE is produced.
- States: IDLE, ITER, FIN.
- IDLE: at a rising edge with START=1, latch OP/A/B and set BUSY.
  - For OP 000-100 and 111, compute the result directly and go to FIN.
  - For MUL/DIV, load the working registers, counter=WIDTH, and go to ITER.
- ITER: one iteration per clock; counter decrements. Go to FIN on the edge where counter reaches 0. MUL/DIV therefore have DONE WIDTH+1 cycles after the accepting edge; other ops have DONE 1 cycle after.
- FIN: DONE=FLAGS_EN=BUSY=1 for exactly one cycle; RESULT/FLAGS/REMAINDER/DIV_ERR updated on entry to FIN; next state IDLE unconditionally.
- START is ignored in ITER and FIN and is not queued. Back-to-back operations need START high in IDLE, so the minimum issue interval is 2 cycles.
- Outputs hold their last values between operations. OP/A/B changes after acceptance have no effect.
- Arithmetic (modulo 2^WIDTH, two's complement for V/N):
  - ADD: C = carry-out; V = operands same sign and result sign differs.
  - SUB (A-B): C = borrow (A<B unsigned); V = operand signs differ and result sign != A sign.
  - AND/OR/XOR: C=0, V=0.
  - MUL: unsigned 2*WIDTH product; RESULT = low WIDTH bits; C = V = (high WIDTH bits != 0).
  - DIV: unsigned; RESULT = quotient, REMAINDER = remainder, C=0, V=0.
  - DIV with B==0: runs the full WIDTH iterations for fixed latency; RESULT = all ones, REMAINDER = A, V=1, C=0, DIV_ERR=1.
  - Reserved 111: RESULT = 0, C=0, V=0.
- All ops: Z = (RESULT==0), N = RESULT[WIDTH-1].
- DIV_ERR is cleared at the next FIN for a non-error operation.

Test Plan:
- Reset then ADD A=8'h7F B=8'h01 -> DONE 1 cycle after accept, RESULT=8'h80, FLAGS=4'b0101, FLAGS_EN single pulse.
- SUB A=8'h05 B=8'h05 -> RESULT=0, FLAGS=4'b1000. Then SUB A=8'h03 B=8'h05 -> RESULT=8'hFE, FLAGS=4'b0110.
- MUL A=8'h10 B=8'h10 -> DONE exactly 9 cycles after accept, RESULT=8'h00, FLAGS=4'b1011. MUL A=8'h0C B=8'h0B -> RESULT=8'h84, FLAGS=4'b0100.
- DIV A=200 B=7 -> RESULT=8'h1C, REMAINDER=8'h04, FLAGS=4'b0000. DIV A=8'h2A B=0 -> RESULT=8'hFF, REMAINDER=8'h2A, DIV_ERR=1, FLAGS=4'b0101.
- START toggled every cycle during a MUL -> only the first accepted; exactly one DONE; BUSY high 9 cycles.
- RESET asserted 4 cycles into a DIV -> all outputs 0 immediately. After release, a new ADD 8'h01+8'h01 gives RESULT=8'h02 with no stale DONE.
